// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS31 pipeline and its stall sequencer.
// master = pipeline side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_is_muldiv;
  logic        id_reads_hilo;
  logic        exe_GPR_we;
  logic [4:0]  exe_GPR_waddr;
  logic        exe_is_load;
  logic        mem_GPR_we;
  logic [4:0]  mem_GPR_waddr;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_ena;
  logic        if_id_ena;
  logic        id_exe_ena;
  logic        id_exe_bubble;
  logic        exe_mem_ena;
  logic        mem_wb_ena;
  logic        md_start;
  logic        md_busy;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs_addr, id_rt_addr,
    output id_rs_used, id_rt_used,
    output id_is_muldiv, id_reads_hilo,
    output exe_GPR_we, exe_GPR_waddr,
    output exe_is_load,
    output mem_GPR_we, mem_GPR_waddr,
    output mem_req, mem_ready,
    input  pc_ena, if_id_ena,
    input  id_exe_ena, id_exe_bubble,
    input  exe_mem_ena, mem_wb_ena,
    input  md_start, md_busy,
    input  stall_cycles
  );

  modport slave (
    input  id_rs_addr, id_rt_addr,
    input  id_rs_used, id_rt_used,
    input  id_is_muldiv, id_reads_hilo,
    input  exe_GPR_we, exe_GPR_waddr,
    input  exe_is_load,
    input  mem_GPR_we, mem_GPR_waddr,
    input  mem_req, mem_ready,
    output pc_ena, if_id_ena,
    output id_exe_ena, id_exe_bubble,
    output exe_mem_ena, mem_wb_ena,
    output md_start, md_busy,
    output stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble sequencer for the 5-stage MIPS31 pipeline with MDU tracking.
// Define PIPE_FORWARD_EN when the forwarding network is present.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  localparam logic [7:0] LAT = 8'(MD_LATENCY);

  md_state_e   state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic rs_exe, rt_exe, exe_hit;
  logic memwait, mdhaz, raw;
  logic stop, hold, run;
  logic md_start;

  // Hazard detection against the EXE (and, without forwarding, MEM) stage.
  always_comb begin
    rs_exe  = hz.id_rs_used & (hz.id_rs_addr == hz.exe_GPR_waddr);
    rt_exe  = hz.id_rt_used & (hz.id_rt_addr == hz.exe_GPR_waddr);
    exe_hit = hz.exe_GPR_we & (hz.exe_GPR_waddr != 5'd0)
            & (rs_exe | rt_exe);
`ifdef PIPE_FORWARD_EN
    raw = hz.exe_is_load & exe_hit;
`else
    raw = exe_hit
        | (hz.mem_GPR_we & (hz.mem_GPR_waddr != 5'd0)
           & ((hz.id_rs_used & (hz.id_rs_addr == hz.mem_GPR_waddr))
            | (hz.id_rt_used & (hz.id_rt_addr == hz.mem_GPR_waddr))));
`endif
    memwait = hz.mem_req & ~hz.mem_ready;
    mdhaz   = (state_q == BUSY) & (hz.id_is_muldiv | hz.id_reads_hilo);
    stop    = ~reset | memwait;
    hold    = ~stop & (mdhaz | raw);
    run     = ~stop & ~hold;
  end

  // Priority-resolved enables; exactly one of stop/hold/run is set.
  always_comb begin
    hz.pc_ena        = 1'b0;
    hz.if_id_ena     = 1'b0;
    hz.id_exe_ena    = 1'b0;
    hz.id_exe_bubble = 1'b0;
    hz.exe_mem_ena   = 1'b0;
    hz.mem_wb_ena    = 1'b0;
    unique case (1'b1)
      stop: ;
      hold: begin
        hz.id_exe_ena    = 1'b1;
        hz.id_exe_bubble = 1'b1;
        hz.exe_mem_ena   = 1'b1;
        hz.mem_wb_ena    = 1'b1;
      end
      run: begin
        hz.pc_ena      = 1'b1;
        hz.if_id_ena   = 1'b1;
        hz.id_exe_ena  = 1'b1;
        hz.exe_mem_ena = 1'b1;
        hz.mem_wb_ena  = 1'b1;
      end
      default: ;
    endcase
    md_start = hz.id_is_muldiv & hz.id_exe_ena & ~hz.id_exe_bubble;
    hz.md_start = md_start;
  end

  // MDU busy tracker and stall counter next state.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d  = BUSY;
          md_cnt_d = LAT;
        end
      end
      BUSY: begin
        md_cnt_d = md_cnt_q - 8'd1;
        if (md_cnt_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_cycles_d = stall_cycles_q + {31'd0, ~hz.pc_ena};
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      md_cnt_q       <= 8'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.md_busy      = (state_q == BUSY);
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MD_LATENCY=4).
// Expected outputs queued at drive time, popped mid-cycle.
module tb_pipeline_hazard_ctrl;

  localparam int LAT = 4;

  typedef struct packed {
    logic        pc, ifid, idexe, bub, exemem, memwb, start, busy;
    logic [31:0] stall;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_stall;
  logic [31:0] base;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.MD_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    hz.id_rs_addr    = 5'd0;
    hz.id_rt_addr    = 5'd0;
    hz.id_rs_used    = 1'b0;
    hz.id_rt_used    = 1'b0;
    hz.id_is_muldiv  = 1'b0;
    hz.id_reads_hilo = 1'b0;
    hz.exe_GPR_we    = 1'b0;
    hz.exe_GPR_waddr = 5'd0;
    hz.exe_is_load   = 1'b0;
    hz.mem_GPR_we    = 1'b0;
    hz.mem_GPR_waddr = 5'd0;
    hz.mem_req       = 1'b0;
    hz.mem_ready     = 1'b0;
  endtask

  function automatic logic hit(input logic [4:0] wa, input logic we);
    return we && wa != 0 &&
      ((hz.id_rs_used && hz.id_rs_addr == wa) ||
       (hz.id_rt_used && hz.id_rt_addr == wa));
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic raw;
    e = '0;
    e.busy  = m_busy;
    e.stall = m_stall;
    if (!reset) return e;
`ifdef PIPE_FORWARD_EN
    raw = hz.exe_is_load && hit(hz.exe_GPR_waddr, hz.exe_GPR_we);
`else
    raw = hit(hz.exe_GPR_waddr, hz.exe_GPR_we) ||
          hit(hz.mem_GPR_waddr, hz.mem_GPR_we);
`endif
    if (hz.mem_req && !hz.mem_ready) begin
      // everything frozen
    end else if ((m_busy && (hz.id_is_muldiv || hz.id_reads_hilo)) || raw) begin
      e.idexe = 1; e.bub = 1; e.exemem = 1; e.memwb = 1;
    end else begin
      e.pc = 1; e.ifid = 1; e.idexe = 1; e.exemem = 1; e.memwb = 1;
      e.start = hz.id_is_muldiv;
    end
    return e;
  endfunction

  task automatic upd(input exp_t e);
    if (!reset) begin
      m_busy = 0; m_cnt = 0; m_stall = 0;
      return;
    end
    m_stall = m_stall + {31'd0, !e.pc};
    if (m_busy) begin
      if (m_cnt == 1) m_busy = 0;
      m_cnt--;
    end else if (e.start) begin
      m_busy = 1;
      m_cnt  = LAT;
    end
  endtask

  task automatic cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("pc_ena", {31'd0, hz.pc_ena}, {31'd0, e.pc});
    chk("if_id_ena", {31'd0, hz.if_id_ena}, {31'd0, e.ifid});
    chk("id_exe_ena", {31'd0, hz.id_exe_ena}, {31'd0, e.idexe});
    chk("bubble", {31'd0, hz.id_exe_bubble}, {31'd0, e.bub});
    chk("exe_mem_ena", {31'd0, hz.exe_mem_ena}, {31'd0, e.exemem});
    chk("mem_wb_ena", {31'd0, hz.mem_wb_ena}, {31'd0, e.memwb});
    chk("md_start", {31'd0, hz.md_start}, {31'd0, e.start});
    chk("md_busy", {31'd0, hz.md_busy}, {31'd0, e.busy});
    chk("stall_cycles", hz.stall_cycles, e.stall);
  endtask

  task automatic step();
    exp_t e;
    e = model();
    sb.push_back(e);
    #2;
    cmp();
    @(posedge clk);
    upd(e);
    #1;
  endtask

  task automatic set_exe(input logic [4:0] wa, input logic ld);
    hz.exe_GPR_we    = 1'b1;
    hz.exe_GPR_waddr = wa;
    hz.exe_is_load   = ld;
  endtask

  task automatic to_mem(input logic [4:0] wa);
    hz.exe_GPR_we    = 1'b0;
    hz.exe_GPR_waddr = 5'd0;
    hz.exe_is_load   = 1'b0;
    hz.mem_GPR_we    = 1'b1;
    hz.mem_GPR_waddr = wa;
  endtask

  initial begin
    m_busy = 0; m_cnt = 0; m_stall = 0;
    idle_in();
    reset = 1'b0;
    #2;
    chk("rst_pc_ena", {31'd0, hz.pc_ena}, 32'd0);
    chk("rst_stall", hz.stall_cycles, 32'd0);
    @(posedge clk); #1;
    step();
    reset = 1'b1;
    step();

    // load-use on rs
    hz.id_rs_used = 1; hz.id_rs_addr = 5'd5;
    set_exe(5'd5, 1'b1);
    base = m_stall;
    step();
    to_mem(5'd5);
    step();
    idle_in();
    step();
`ifdef PIPE_FORWARD_EN
    chk("lu_stalls", m_stall - base, 32'd1);
`else
    chk("lu_stalls", m_stall - base, 32'd2);
`endif

    // ALU-use on rt
    hz.id_rt_used = 1; hz.id_rt_addr = 5'd7;
    set_exe(5'd7, 1'b0);
    base = m_stall;
    step();
    to_mem(5'd7);
    step();
    idle_in();
    step();
`ifdef PIPE_FORWARD_EN
    chk("alu_stalls", hz.stall_cycles - base, 32'd0);
`else
    chk("alu_stalls", hz.stall_cycles - base, 32'd2);
`endif

    // $0 destination never stalls
    hz.id_rt_used = 1; hz.id_rt_addr = 5'd0;
    set_exe(5'd0, 1'b1);
    hz.mem_GPR_we = 1;
    base = m_stall;
    step();
    idle_in();
    step();
    chk("r0_stalls", hz.stall_cycles - base, 32'd0);

    // mult then mflo waits out MD_LATENCY
    hz.id_is_muldiv = 1;
    step();
    hz.id_is_muldiv  = 0;
    hz.id_reads_hilo = 1;
    base = m_stall;
    for (int i = 0; i < 10 && m_busy; i++) step();
    chk("md_bound", {31'd0, m_busy}, 32'd0);
    step();
    chk("mflo_stalls", hz.stall_cycles - base, LAT);
    idle_in();
    step();

    // memory wait with load-use pending, MDU counting down
    hz.id_is_muldiv = 1;
    step();
    idle_in();
    hz.id_rs_used = 1; hz.id_rs_addr = 5'd9;
    set_exe(5'd9, 1'b1);
    hz.mem_req = 1; hz.mem_ready = 0;
    repeat (3) step();
    hz.mem_ready = 1;
    step();
    to_mem(5'd9);
    hz.mem_req = 0;
    step();
    idle_in();
    repeat (3) step();
    chk("mw_busy_done", {31'd0, hz.md_busy}, 32'd0);

    // async reset in the middle of BUSY
    hz.id_is_muldiv = 1;
    step();
    idle_in();
    step();
    #3;
    reset = 1'b0;
    #1;
    chk("t1_busy", {31'd0, hz.md_busy}, 32'd0);
    chk("t1_stall", hz.stall_cycles, 32'd0);
    chk("t1_pc_ena", {31'd0, hz.pc_ena}, 32'd0);
    m_busy = 0; m_cnt = 0; m_stall = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    // stall counter wrap
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    m_stall = 32'hFFFF_FFFF;
    hz.id_rs_used = 1; hz.id_rs_addr = 5'd3;
    set_exe(5'd3, 1'b1);
    step();
    chk("t6_wrap", hz.stall_cycles, 32'd0);
    idle_in();
    step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
